// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch path.
// Instruction words are numbered [0:31] with bit 0 as the MSB.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    VALID = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam int OP_FIRST  = 26;
  localparam int OP_LAST   = 31;
  localparam int IMM_FIRST = 0;
  localparam int IMM_LAST  = 15;
  localparam int TGT_FIRST = 0;
  localparam int TGT_LAST  = 25;

  // Word-aligned byte offset from a 16-bit signed immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection: sequential, taken branch, or jump.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic [0:TGT_LAST] instr_hi,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  output logic [31:0]       next_pc
);

  logic [31:0] seq;
  logic [15:0] imm;
  logic [25:0] target;

  assign seq    = pc + 32'd4;
  assign imm    = instr_hi[IMM_FIRST:IMM_LAST];
  assign target = instr_hi[TGT_FIRST:TGT_LAST];

  always_comb begin
    next_pc = seq;
    if (jump) begin
      next_pc = {seq[31:28], target, 2'b00};
    end else if (branch && zero) begin
      next_pc = seq + branch_offset(imm);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer: fetches over req/ack, presents words
// to the decoder over valid/ready, and steers the PC from Jump/branch/zero.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        R_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_rdata,
  output logic [0:31] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  input  logic        Jump,
  input  logic        branch,
  input  logic        zero,
  output logic        fetch_err
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_out_reg;
  logic [0:31] instr_reg;
  logic [15:0] cnt_reg, cnt_next;
  logic        armed_reg;
  logic        load;
  logic        accept;
  logic [31:0] next_pc;

  // armed_reg holds the request off for the first cycle out of reset so an
  // ack left over from an aborted transfer cannot complete a new fetch.
  assign imem_req    = (state_reg == REQ) && armed_reg;
  assign imem_addr   = pc_reg;
  assign instr_valid = (state_reg == VALID);
  assign fetch_err   = (state_reg == ERR);
  assign instr       = instr_reg;
  assign pc_out      = pc_out_reg;
  assign load        = imem_req && imem_ack;
  assign accept      = instr_valid && instr_ready;

  next_pc_calc u_next_pc (
    .pc       (pc_reg),
    .instr_hi (instr_reg[TGT_FIRST:TGT_LAST]),
    .jump     (Jump),
    .branch   (branch),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      REQ: begin
        if (imem_req) begin
          if (imem_ack) begin
            state_next = VALID;
          end else if (cnt_reg == 16'(TIMEOUT - 1)) begin
            state_next = ERR;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
      end
      VALID: begin
        if (instr_ready) begin
          state_next = REQ;
          cnt_next   = '0;
        end
      end
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      state_reg  <= REQ;
      pc_reg     <= RESET_PC;
      pc_out_reg <= RESET_PC;
      instr_reg  <= '0;
      cnt_reg    <= '0;
      armed_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      armed_reg <= 1'b1;
      if (load) begin
        instr_reg  <= imem_rdata;
        pc_out_reg <= pc_reg;
      end
      if (accept) begin
        pc_reg <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// fetch/accept walk checked against an arithmetic PC model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TO  = 4;

  logic        clk = 1'b0;
  logic        R_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc_out;
  logic        Jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        fetch_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mpc;
  logic [31:0] cur_word;

  fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .R_n         (R_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_out      (pc_out),
    .Jump        (Jump),
    .branch      (branch),
    .zero        (zero),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Reference next-PC: word-level arithmetic on a normally numbered word
  // (tb bit 31 is the DUT's bit 0).
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit j, input bit b, input bit z);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | (32'(w[31:6]) * 32'd4);
    if (b && z) return seq + 32'(int'($signed(w[31:16])) * 4);
    return seq;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) break;
      @(negedge clk);
    end
    chk("req_seen", imem_req, 1);
  endtask

  task automatic fetch(input logic [31:0] word, input int dly);
    wait_req();
    chk("addr", imem_addr, mpc);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, mpc);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    cur_word = word;
    chk("valid", instr_valid, 1);
    chk("instr", instr, word);
    chk("pc_out", pc_out, mpc);
    chk("req_low", imem_req, 0);
  endtask

  task automatic accept(input bit j, input bit b, input bit z, input int stall);
    logic [31:0] nxt;
    for (int i = 0; i < stall; i++) begin
      Jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom);
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
      chk("stall_valid", instr_valid, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_instr", instr, cur_word);
      chk("stall_pc_out", pc_out, mpc);
    end
    imem_ack = 1'b0;
    Jump = j; branch = b; zero = z;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    Jump = 1'b0; branch = 1'b0; zero = 1'b0;
    nxt = model_next(mpc, cur_word, j, b, z);
    $display("xfer pc=%h instr=%h J=%0d b=%0d z=%0d stall=%0d next=%h",
             mpc, cur_word, j, b, z, stall, nxt);
    mpc = nxt;
    chk("valid_drop", instr_valid, 0);
    chk("next_req", imem_req, 1);
    chk("next_addr", imem_addr, mpc);
  endtask

  initial begin
    mpc = RPC;
    cur_word = '0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_instr", instr, 32'h0);
    R_n = 1'b1;

    // Sequential fetch 0x0, 0x4, 0x8 with 1-cycle ack delay
    fetch({26'h0, 6'd0}, 1); accept(0, 0, 0, 0);
    fetch({26'h123, 6'd35}, 1); accept(0, 0, 0, 0);
    // BEQ imm=-2 taken: 0x8+4-8 = 0x4
    fetch({16'hFFFE, 10'h0, 6'd4}, 1); accept(0, 1, 1, 0);
    chk("beq_taken_abs", imem_addr, 32'h4);
    fetch({26'h55, 6'd43}, 0); accept(0, 0, 0, 0);
    // Same BEQ not taken -> 0xC
    fetch({16'hFFFE, 10'h0, 6'd4}, 0); accept(0, 1, 0, 0);
    chk("beq_nt_abs", imem_addr, 32'hC);

    // Jump to top of region 0, then fall through into 0x1000_0000
    fetch({26'h3FF_FFFF, 6'd2}, 0); accept(1, 0, 0, 0);
    chk("jump_max_abs", imem_addr, 32'h0FFF_FFFC);
    fetch({26'h0, 6'd0}, 0); accept(0, 0, 0, 0);
    chk("region_cross", imem_addr, 32'h1000_0000);
    for (int i = 0; i < 4; i++) begin
      fetch($urandom & 32'hFFFF_FFC0, 0); accept(0, 0, 0, 0);
    end
    // Jump at 0x1000_0010 with branch also high: jump wins
    fetch({26'h40, 6'd2}, 2); accept(1, 1, 1, 0);
    chk("jump_abs", imem_addr, 32'h1000_0100);

    // Five stall cycles with noise on control and a stray ack
    fetch($urandom, 1); accept(0, 0, 0, 5);

    // Randomized walk
    for (int n = 0; n < 40; n++) begin
      fetch($urandom, $urandom_range(0, 3));
      accept(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    // Timeout: ack withheld for TO request cycles
    wait_req();
    for (int i = 0; i < TO; i++) begin
      chk("to_req", imem_req, 1);
      chk("to_err_low", fetch_err, 0);
      @(negedge clk);
    end
    chk("to_err", fetch_err, 1);
    chk("to_req_drop", imem_req, 0);
    chk("to_valid", instr_valid, 0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_err", fetch_err, 1);
    chk("late_ack_valid", instr_valid, 0);
    $display("xfer timeout fetch_err=%0d", fetch_err);
    R_n = 1'b0;
    #1;
    chk("err_clear", fetch_err, 0);
    chk("err_rst_req", imem_req, 0);
    @(negedge clk);
    R_n = 1'b1;
    mpc = RPC;

    // Reach 0x20, then reset in the middle of its request
    fetch({26'h8, 6'd2}, 0); accept(1, 0, 0, 0);
    chk("jump20_abs", imem_addr, 32'h20);
    #2;
    R_n = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    R_n = 1'b1;
    mpc = RPC;
    @(negedge clk);
    chk("rst_ack_valid", instr_valid, 0);
    chk("rst_ack_instr", instr, 32'h0);
    imem_ack = 1'b0;
    $display("xfer mid-request reset, restart at %h", imem_addr);
    fetch($urandom, 1); accept(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch and PC sequencer: the producer end of the instruction-to-control path.
- Holds the PC, fetches words from instruction memory over a req/ack handshake, and presents each word to the control decoder with a valid/ready handshake.
- Consumes the decoder's Jump and branch signals plus the ALU zero flag to choose the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles imem_req may wait for imem_ack before the error state (range 1..65535).

Ports:
- clk  in  1  clock, rising edge.
- R_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  32  byte address of fetch (= pc).
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  [0:31]  fetched word; opcode at bits 26..31, bit 0 is MSB.
- instr  out  [0:31]  instruction presented to the decoder.
- instr_valid  out  1  instr holds a fetched word.
- instr_ready  in  1  downstream accepts instr this cycle.
- pc_out  out  32  address of the word currently in instr.
- Jump  in  1  from control: unconditional jump for the presented instr.
- branch  in  1  from control: conditional branch for the presented instr.
- zero  in  1  from ALU: branch condition.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (R_n low, async):
  - state=REQ, pc=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0 during reset; fetch_err=0.
  - Reset mid-handshake aborts the transfer; any later imem_ack before a new request is ignored.
- States: REQ, VALID, ERR.
- REQ:
  - imem_req=1, imem_addr=pc, both held stable until ack. Wait counter increments each cycle.
  - imem_ack=1 -> instr<=imem_rdata, pc_out<=pc, go VALID. Ack in the first REQ cycle is legal, giving 1-cycle latency from ack to instr_valid.
  - Counter reaching TIMEOUT without ack -> go ERR.
- VALID:
  - instr_valid=1, imem_req=0. instr and pc_out stay stable while instr_ready=0.
  - instr_valid&instr_ready -> pc<=next_pc, counter cleared, go REQ.
  - The next request is issued the cycle after acceptance, so back-to-back words arrive at most one every 2 cycles.
- next_pc, sampled in the accept cycle, 32-bit arithmetic with wrap-around modulo 2^32:
  - seq = pc+4.
  - Jump=1 -> {seq[31:28], instr[0:25], 2'b00}. Jump takes priority over branch if both are high.
  - branch=1 and zero=1 -> seq + (sign-extended instr[0:15] << 2); instr[0] is the sign bit.
  - Otherwise -> seq.
- ERR:
  - fetch_err=1, imem_req=0, instr_valid=0. Exit only via reset.
- Input handling:
  - Jump, branch and zero are ignored in any cycle without acceptance.
  - imem_ack outside REQ is ignored.
  - Bits 1:0 of pc are always 0; RESET_PC must be word-aligned.

Decomposition:
- Shared package holds:
  - State encoding (REQ, VALID, ERR).
  - Opcode constants: OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_LW=35, OP_SW=43.
  - Field-slice constants: opcode 26..31, imm 0..15, target 0..25.
- One sub-module, next_pc_calc: combinational seq/branch/jump target selection, testable on its own.

Test Plan:
- Reset release with RESET_PC=0, memory acks after 1 cycle, instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid one cycle after each ack; fetch_err=0.
- Word at 0x8 is BEQ with imm16=16'hFFFE, branch=1, zero=1 at accept -> next imem_addr = 0x8+4-8 = 0x4. Same word with zero=0 -> next address 0xC.
- Jump at pc=0x1000_0010 with target26=26'h000_0040, Jump=1 -> next imem_addr=0x1000_0100. Jump=1 and branch=1 together -> the jump target is taken.
- instr_ready low for 5 cycles in VALID -> instr and pc_out unchanged, no imem_req, exactly one advance when ready rises.
- TIMEOUT=4 with ack withheld -> fetch_err rises after 4 REQ cycles with imem_req dropped; a late ack is ignored; R_n pulse clears fetch_err and refetches RESET_PC.
- R_n asserted mid-REQ at pc=0x20 -> imem_req drops immediately; after release fetch restarts at RESET_PC; an ack arriving during reset is ignored.
